// File: rtl/ft8_symbol_mapper.sv
//============================================================================
// Module   : ft8_symbol_mapper
// Function : Captures a 174-bit LDPC codeword and streams the 79-symbol FT8
//            frame (Costas sync + Gray-mapped data) over a valid/ready port.
// Options  : FT8_SYMBOL_MAPPER_OVERRUN_EN adds a sticky overrun flag.
// Revision : 1.0
//============================================================================
`default_nettype none

module ft8_symbol_mapper #(
  parameter int GRAY_EN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [173:0] codeword,
  input  logic         codeword_valid,
  output logic [2:0]   symbol,
  output logic         symbol_valid,
  input  logic         symbol_ready,
  output logic         busy,
  output logic         frame_start,
  output logic         frame_done
`ifdef FT8_SYMBOL_MAPPER_OVERRUN_EN
  ,
  input  logic         overrun_clr,
  output logic         overrun
`endif
);

  localparam logic [0:0] C_IDLE       = 1'b0;
  localparam logic [0:0] C_SEND       = 1'b1;
  localparam logic [6:0] C_LAST_INDEX = 7'd78;
  localparam int         C_NUM_DATA   = 58;

  logic [0:0]   r_state;
  logic [0:0]   w_state_next;
  logic [6:0]   r_index;
  logic [173:0] r_codeword;

  logic         w_handshake;
  logic [6:0]   w_lookup_index;
  logic         w_is_data;
  logic [2:0]   w_costas_pos;
  logic [5:0]   w_data_k;
  logic [2:0]   w_raw [C_NUM_DATA];
  logic [2:0]   w_raw_sel;
  logic [2:0]   w_data_tone;
  logic [2:0]   w_costas_tone;
  logic [2:0]   w_tone;

  logic [2:0]   w_symbol_next;
  logic         w_valid_next;
  logic         w_busy_next;
  logic         w_start_next;
  logic         w_done_next;
  logic [6:0]   w_index_next;
  logic         w_load_codeword;

  assign w_handshake = symbol_valid & symbol_ready;

  // Each data symbol takes three consecutive codeword bits, lowest index as MSB.
  generate
    for (genvar gi = 0; gi < C_NUM_DATA; gi++) begin : g_raw
      assign w_raw[gi] = {r_codeword[3*gi], r_codeword[3*gi+1], r_codeword[3*gi+2]};
    end
  endgenerate

  // Tone for the symbol about to be loaded: index 0 on capture, else index+1.
  always_comb begin
    w_lookup_index = (r_state == C_IDLE) ? 7'd0 : r_index + 7'd1;
    w_is_data      = 1'b0;
    w_costas_pos   = 3'd0;
    w_data_k       = 6'd0;
    if (w_lookup_index < 7'd7) begin
      w_costas_pos = w_lookup_index[2:0];
    end else if (w_lookup_index < 7'd36) begin
      w_is_data = 1'b1;
      w_data_k  = 6'(w_lookup_index - 7'd7);
    end else if (w_lookup_index < 7'd43) begin
      w_costas_pos = 3'(w_lookup_index - 7'd36);
    end else if (w_lookup_index < 7'd72) begin
      w_is_data = 1'b1;
      w_data_k  = 6'(w_lookup_index - 7'd14);
    end else begin
      w_costas_pos = 3'(w_lookup_index - 7'd72);
    end
  end

  assign w_raw_sel = w_raw[w_data_k];

  always_comb begin
    case (w_costas_pos)
      3'd0:    w_costas_tone = 3'd3;
      3'd1:    w_costas_tone = 3'd1;
      3'd2:    w_costas_tone = 3'd4;
      3'd3:    w_costas_tone = 3'd0;
      3'd4:    w_costas_tone = 3'd6;
      3'd5:    w_costas_tone = 3'd5;
      3'd6:    w_costas_tone = 3'd2;
      default: w_costas_tone = 3'd0;
    endcase
  end

  generate
    if (GRAY_EN != 0) begin : g_gray_map
      always_comb begin
        case (w_raw_sel)
          3'd0:    w_data_tone = 3'd0;
          3'd1:    w_data_tone = 3'd1;
          3'd2:    w_data_tone = 3'd3;
          3'd3:    w_data_tone = 3'd2;
          3'd4:    w_data_tone = 3'd5;
          3'd5:    w_data_tone = 3'd6;
          3'd6:    w_data_tone = 3'd4;
          default: w_data_tone = 3'd7;
        endcase
      end
    end else begin : g_gray_bypass
      assign w_data_tone = w_raw_sel;
    end
  endgenerate

  assign w_tone = w_is_data ? w_data_tone : w_costas_tone;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= C_IDLE;
      r_index      <= 7'd0;
      r_codeword   <= '0;
      symbol       <= 3'd0;
      symbol_valid <= 1'b0;
      busy         <= 1'b0;
      frame_start  <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_index      <= w_index_next;
      if (w_load_codeword) begin
        r_codeword <= codeword;
      end
      symbol       <= w_symbol_next;
      symbol_valid <= w_valid_next;
      busy         <= w_busy_next;
      frame_start  <= w_start_next;
      frame_done   <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      C_IDLE: if (codeword_valid) w_state_next = C_SEND;
      C_SEND: if (w_handshake && (r_index == C_LAST_INDEX)) w_state_next = C_IDLE;
      default: w_state_next = C_IDLE;
    endcase
  end

  always_comb begin
    w_symbol_next   = symbol;
    w_valid_next    = symbol_valid;
    w_busy_next     = busy;
    w_start_next    = 1'b0;
    w_done_next     = 1'b0;
    w_index_next    = r_index;
    w_load_codeword = 1'b0;
    case (r_state)
      C_IDLE: begin
        if (codeword_valid) begin
          w_load_codeword = 1'b1;
          w_index_next    = 7'd0;
          w_symbol_next   = w_tone;
          w_valid_next    = 1'b1;
          w_busy_next     = 1'b1;
          w_start_next    = 1'b1;
        end
      end
      C_SEND: begin
        if (w_handshake) begin
          if (r_index == C_LAST_INDEX) begin
            w_index_next  = 7'd0;
            w_symbol_next = 3'd0;
            w_valid_next  = 1'b0;
            w_busy_next   = 1'b0;
            w_done_next   = 1'b1;
          end else begin
            w_index_next  = r_index + 7'd1;
            w_symbol_next = w_tone;
          end
        end
      end
      default: begin
        w_valid_next = 1'b0;
        w_busy_next  = 1'b0;
      end
    endcase
  end

`ifdef FT8_SYMBOL_MAPPER_OVERRUN_EN
  // Sticky flag for strobes dropped while a frame is in flight; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (codeword_valid && busy) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire
